// File: rtl/spi_matmul_pkg.sv
// Shared definitions for the SPI matrix-multiply tile: FSM states, command
// field layout, and width helpers used by the engine and its dot product.
package spi_matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_OUTPUT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [3:0] CMD_MAGIC_DEFAULT = 4'hA;
  localparam int CMD_BITS      = 8;
  localparam int CMD_MAGIC_MSB = 7;
  localparam int CMD_MAGIC_LSB = 4;
  localparam int CMD_SAT_BIT   = 0;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Full-precision width of an N-term sum of DW x DW products.
  function automatic int sum_width(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

endpackage

// File: rtl/spi_matmul_engine_if.sv
// SPI pin bundle of the matmul tile plus its status flags.
interface spi_matmul_engine_if;
  logic spi_cs_n;
  logic spi_sdi;
  logic spi_sdo;
  logic busy_o;
  logic done_o;
  logic err_o;

  modport slave (
    input  spi_cs_n,
    input  spi_sdi,
    output spi_sdo,
    output busy_o,
    output done_o,
    output err_o
  );

  modport master (
    output spi_cs_n,
    output spi_sdi,
    input  spi_sdo,
    input  busy_o,
    input  done_o,
    input  err_o
  );
endinterface

// File: rtl/spi_matmul_dot.sv
// Combinational N-term dot product with wrap/saturate output stage.
// SPI_MATMUL_SIGNED_EN: when defined, operands and sum are two's complement
// and saturation clamps to the signed RW-bit range.
module spi_matmul_dot
  import spi_matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int RW = 8,
  parameter int SW = sum_width(DW, N)
) (
  input  logic [N*DW-1:0] row,
  input  logic [N*DW-1:0] col,
  input  logic            sat_mode,
  output logic [RW-1:0]   res
);

`ifdef SPI_MATMUL_SIGNED_EN
  localparam logic [SW-1:0] MAX_V = {SW{1'b1}} >> (SW - RW + 1);
  localparam logic [SW-1:0] MIN_V = ~MAX_V;

  function automatic logic [RW-1:0] saturate(input logic signed [SW-1:0] v);
    if (v > $signed(MAX_V)) return MAX_V[RW-1:0];
    else if (v < $signed(MIN_V)) return MIN_V[RW-1:0];
    else return v[RW-1:0];
  endfunction

  logic signed [2*DW-1:0] prod;
  logic signed [SW-1:0]   sum;

  // Signed multiply-accumulate across the row/column pair.
  always_comb begin
    prod = '0;
    sum  = '0;
    for (int t = 0; t < N; t++) begin
      prod = $signed(row[t*DW +: DW]) * $signed(col[t*DW +: DW]);
      sum  = sum + {{(SW-2*DW){prod[2*DW-1]}}, prod};
    end
  end
`else
  localparam logic [SW-1:0] MAX_V = {SW{1'b1}} >> (SW - RW);

  function automatic logic [RW-1:0] saturate(input logic [SW-1:0] v);
    if (v > MAX_V) return MAX_V[RW-1:0];
    else return v[RW-1:0];
  endfunction

  logic [2*DW-1:0] prod;
  logic [SW-1:0]   sum;

  // Unsigned multiply-accumulate across the row/column pair.
  always_comb begin
    prod = '0;
    sum  = '0;
    for (int t = 0; t < N; t++) begin
      prod = row[t*DW +: DW] * col[t*DW +: DW];
      sum  = sum + {{(SW-2*DW){1'b0}}, prod};
    end
  end
`endif

  assign res = sat_mode ? saturate(sum) : sum[RW-1:0];

endmodule

// File: rtl/spi_matmul_engine.sv
// SPI-slave NxN matrix multiplier (mode 0). Receives a command byte, then
// A and B row-major, and streams C = A x B back MSB first. The receive FSM
// runs on rising edges, result shifting on falling edges. Optional signed
// arithmetic is selected with SPI_MATMUL_SIGNED_EN (see spi_matmul_dot).
module spi_matmul_engine
  import spi_matmul_pkg::*;
#(
  parameter int         N         = 2,
  parameter int         DW        = 8,
  parameter int         RW        = 8,
  parameter logic [3:0] CMD_MAGIC = CMD_MAGIC_DEFAULT
) (
  input logic               spi_clk,
  input logic               rst_n,
  spi_matmul_engine_if.slave bus
);

  localparam int SW  = sum_width(DW, N);
  localparam int NE  = N * N;
  localparam int EW  = clog2(NE);
  localparam int RXW = (DW > CMD_BITS) ? DW : CMD_BITS;
  localparam int BW  = clog2(RXW);
  localparam int IW  = clog2(N);
  localparam int TW  = clog2(RW);

  // Chip select high clears the transaction state just like reset does.
  logic clr_n;
  assign clr_n = rst_n & ~bus.spi_cs_n;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [EW-1:0]   elem_cnt;
  logic [RXW-2:0]  rx;
  logic [RXW-1:0]  rx_next;
  logic            sat_mode;
  logic            busy_r;
  logic            err_r;
  logic            done_r;
  logic            sdo_r;
  logic [IW-1:0]   row_i;
  logic [IW-1:0]   col_j;
  logic [TW-1:0]   tx_bit;
  logic [RW-2:0]   tx;
  logic [DW-1:0]   mem_a [NE];
  logic [DW-1:0]   mem_b [NE];
  logic [N*DW-1:0] row_v;
  logic [N*DW-1:0] col_v;
  logic [RW-1:0]   dot_res;
  logic            cmd_last;
  logic            elem_done;
  logic            elem_last;
  logic            wr_a;
  logic            wr_b;

  assign rx_next   = {rx, bus.spi_sdi};
  assign cmd_last  = (bit_cnt == BW'(CMD_BITS - 1));
  assign elem_done = (bit_cnt == BW'(DW - 1));
  assign elem_last = (elem_cnt == EW'(NE - 1));
  assign wr_a      = (state == ST_LOAD_A) && elem_done;
  assign wr_b      = (state == ST_LOAD_B) && elem_done;

  // Receive FSM: shift SDI in, frame command and operand elements.
  always_ff @(posedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      elem_cnt <= '0;
      rx       <= '0;
      sat_mode <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rx <= rx_next[RXW-2:0];
      case (state)
        ST_IDLE: begin
          state   <= ST_CMD;
          busy_r  <= 1'b1;
          bit_cnt <= BW'(1);
        end
        ST_CMD: begin
          if (cmd_last) begin
            bit_cnt <= '0;
            if (rx_next[CMD_MAGIC_MSB:CMD_MAGIC_LSB] == CMD_MAGIC) begin
              sat_mode <= rx_next[CMD_SAT_BIT];
              state    <= ST_LOAD_A;
            end else begin
              state  <= ST_ERROR;
              busy_r <= 1'b0;
              err_r  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_LOAD_A, ST_LOAD_B: begin
          if (elem_done) begin
            bit_cnt <= '0;
            if (elem_last) begin
              elem_cnt <= '0;
              state    <= (state == ST_LOAD_A) ? ST_LOAD_B : ST_OUTPUT;
            end else begin
              elem_cnt <= elem_cnt + EW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_OUTPUT: begin
          if (done_r) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand storage survives chip-select deassertion; only rst_n clears it.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NE; e++) begin
        mem_a[e] <= '0;
        mem_b[e] <= '0;
      end
    end else begin
      if (wr_a) mem_a[elem_cnt] <= rx_next[DW-1:0];
      if (wr_b) mem_b[elem_cnt] <= rx_next[DW-1:0];
    end
  end

  // Select row i of A and column j of B for the element being launched.
  always_comb begin
    row_v = '0;
    col_v = '0;
    for (int t = 0; t < N; t++) begin
      row_v[t*DW +: DW] = mem_a[EW'(int'(row_i) * N + t)];
      col_v[t*DW +: DW] = mem_b[EW'(t * N + int'(col_j))];
    end
  end

  spi_matmul_dot #(
    .N (N),
    .DW(DW),
    .RW(RW),
    .SW(SW)
  ) u_dot (
    .row     (row_v),
    .col     (col_v),
    .sat_mode(sat_mode),
    .res     (dot_res)
  );

  // Transmit side: load each result at bit 0, then shift out MSB first.
  always_ff @(negedge spi_clk or negedge clr_n) begin
    if (!clr_n) begin
      row_i  <= '0;
      col_j  <= '0;
      tx_bit <= '0;
      tx     <= '0;
      sdo_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (done_r || state != ST_OUTPUT) begin
      sdo_r <= 1'b0;
    end else begin
      if (tx_bit == '0) begin
        tx    <= dot_res[RW-2:0];
        sdo_r <= dot_res[RW-1];
      end else begin
        tx    <= {tx[RW-3:0], 1'b0};
        sdo_r <= tx[RW-2];
      end
      if (tx_bit == TW'(RW - 1)) begin
        tx_bit <= '0;
        if (row_i == IW'(N - 1) && col_j == IW'(N - 1)) begin
          done_r <= 1'b1;
        end else if (col_j == IW'(N - 1)) begin
          col_j <= '0;
          row_i <= row_i + IW'(1);
        end else begin
          col_j <= col_j + IW'(1);
        end
      end else begin
        tx_bit <= tx_bit + TW'(1);
      end
    end
  end

  assign bus.spi_sdo = sdo_r;
  assign bus.busy_o  = busy_r & ~done_r;
  assign bus.done_o  = done_r;
  assign bus.err_o   = err_r;

endmodule

// File: tb/tb_spi_matmul_engine.sv
// Directed bench for spi_matmul_engine: a 2x2 and a 3x3 instance share the
// SPI clock; the host drives SDI in the low phase and samples SDO just after
// each rising edge.
module tb_spi_matmul_engine;

  logic spi_clk;
  logic rst_n;
  logic sel;
  int   checks;
  int   errors;
  logic [7:0] rb;
  logic       b;
  logic [7:0] last_byte;

  spi_matmul_engine_if bus2();
  spi_matmul_engine_if bus3();

  spi_matmul_engine #(.N(2), .DW(8), .RW(8)) dut2 (
    .spi_clk(spi_clk),
    .rst_n  (rst_n),
    .bus    (bus2)
  );

  spi_matmul_engine #(.N(3), .DW(8), .RW(8)) dut3 (
    .spi_clk(spi_clk),
    .rst_n  (rst_n),
    .bus    (bus3)
  );

  initial spi_clk = 1'b0;
  always #5 spi_clk = ~spi_clk;

  function automatic logic [3:0] flags();
    if (sel) return {bus3.spi_sdo, bus3.busy_o, bus3.done_o, bus3.err_o};
    else     return {bus2.spi_sdo, bus2.busy_o, bus2.done_o, bus2.err_o};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called in the clock-low phase; returns in the next clock-low phase.
  task automatic send_bit(input logic d, output logic so);
    bus2.spi_sdi = d;
    bus3.spi_sdi = d;
    @(posedge spi_clk);
    #1;
    so = sel ? bus3.spi_sdo : bus2.spi_sdo;
    @(negedge spi_clk);
    #1;
  endtask

  task automatic xfer_byte(input logic [7:0] d, output logic [7:0] r);
    logic so;
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], so);
      r[i] = so;
    end
  endtask

  task automatic send_seq(input logic [127:0] data, input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) xfer_byte(data[8*(n-1-i) +: 8], r);
  endtask

  task automatic recv_check(input string tag, input logic [127:0] exp, input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'h00, r);
      check($sformatf("%s[%0d]", tag, i), {24'h0, r}, {24'h0, exp[8*(n-1-i) +: 8]});
    end
  endtask

  task automatic cs_begin();
    if (sel) bus3.spi_cs_n = 1'b0;
    else     bus2.spi_cs_n = 1'b0;
  endtask

  task automatic cs_end();
    bus2.spi_cs_n = 1'b1;
    bus3.spi_cs_n = 1'b1;
    bus2.spi_sdi  = 1'b0;
    bus3.spi_sdi  = 1'b0;
    @(negedge spi_clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel = 1'b0;
    rst_n = 1'b0;
    bus2.spi_cs_n = 1'b1;
    bus3.spi_cs_n = 1'b1;
    bus2.spi_sdi = 1'b0;
    bus3.spi_sdi = 1'b0;
    repeat (2) @(negedge spi_clk);
    #1;
    check("reset_flags", {28'h0, flags()}, 32'h0);
    rst_n = 1'b1;
    @(negedge spi_clk);
    #1;

    // Scenario 1: basic 2x2 product
    cs_begin();
    xfer_byte(8'hA0, rb);
    check("t1_busy_after_cmd", {28'h0, flags()}, 32'h4);
    send_seq(32'h01020304, 4);
    send_seq(32'h05060708, 4);
    check("t1_before_output", {28'h0, flags()}, 32'h4);
    recv_check("t1_c", 32'h13162B32, 4);
    check("t1_done_flags", {28'h0, flags()}, 32'h2);
    xfer_byte(8'hFF, rb);
    check("t1_sdo_after_done", {24'h0, rb}, 32'h0);
    cs_end();
    check("t1_cs_clears", {28'h0, flags()}, 32'h0);

    // Scenario 2: wrap then saturate
    cs_begin();
    xfer_byte(8'hA0, rb);
    send_seq(32'hC8C80101, 4);
    send_seq(32'h02000002, 4);
    recv_check("t2_wrap", 32'h90900202, 4);
    cs_end();
    cs_begin();
    xfer_byte(8'hA1, rb);
    send_seq(32'hC8C80101, 4);
    send_seq(32'h02000002, 4);
`ifdef SPI_MATMUL_SIGNED_EN
    recv_check("t2_sat", 32'h90900202, 4);
`else
    recv_check("t2_sat", 32'hFFFF0202, 4);
`endif
    cs_end();

    // Scenario 3: bad command
    cs_begin();
    xfer_byte(8'h51, rb);
    check("t3_err_flags", {28'h0, flags()}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      xfer_byte(8'h5A, rb);
      check($sformatf("t3_sdo_idle[%0d]", i), {24'h0, rb}, 32'h0);
    end
    cs_end();
    check("t3_cs_clears_err", {28'h0, flags()}, 32'h0);

    // Scenario 4: abort mid-B, full retry, then reset mid-output
    cs_begin();
    xfer_byte(8'hA0, rb);
    send_seq(32'h01020304, 4);
    send_seq(24'h050607, 3);
    cs_end();
    check("t4_abort_flags", {28'h0, flags()}, 32'h0);
    cs_begin();
    xfer_byte(8'hA0, rb);
    send_seq(32'h01020304, 4);
    send_seq(32'h05060708, 4);
    recv_check("t4_retry", 32'h13162B32, 4);
    check("t4_retry_done", {28'h0, flags()}, 32'h2);
    cs_end();
    cs_begin();
    xfer_byte(8'hA0, rb);
    send_seq(32'h01020304, 4);
    send_seq(32'h05060708, 4);
    recv_check("t4_pre_rst", 32'h13, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, b);
    check("t4_mid_output", {28'h0, flags()}, 32'hC);
    rst_n = 1'b0;
    #1;
    check("t4_rst_async", {28'h0, flags()}, 32'h0);
    #2;
    rst_n = 1'b1;
    cs_end();

    // Scenario 5: 3x3 identity times 1..9
    sel = 1'b1;
    cs_begin();
    xfer_byte(8'hA0, rb);
    send_seq(72'h010000000100000001, 9);
    send_seq(72'h010203040506070809, 9);
    recv_check("t5_c", 64'h0102030405060708, 8);
    last_byte = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b0, b);
      last_byte[i] = b;
      if (i == 2) check("t5_done_before_last", {31'h0, bus3.done_o}, 32'h0);
      if (i == 1) check("t5_done_at_last", {31'h0, bus3.done_o}, 32'h1);
    end
    check("t5_c[8]", {24'h0, last_byte}, 32'h9);
    cs_end();
    sel = 1'b0;

`ifdef SPI_MATMUL_SIGNED_EN
    // Scenario 6: signed operands
    cs_begin();
    xfer_byte(8'hA1, rb);
    send_seq(32'hFF0203FC, 4);
    send_seq(32'h01000001, 4);
    recv_check("t6_ident", 32'hFF0203FC, 4);
    cs_end();
    cs_begin();
    xfer_byte(8'hA1, rb);
    send_seq(32'h80800000, 4);
    send_seq(32'h7F007F00, 4);
    recv_check("t6_sat_neg", 32'h80000000, 4);
    cs_end();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
